// File: rtl/alu_share_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter_if
// Description : Request/response channels of both requesters plus the ALU bus
//               seen by alu_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_share_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 7
);
    logic                  req0_valid_i;
    logic                  req0_ready_o;
    logic [OP_WIDTH-1:0]   req0_op_i;
    logic [DATA_WIDTH-1:0] req0_a_i;
    logic [DATA_WIDTH-1:0] req0_b_i;
    logic [DATA_WIDTH-1:0] req0_c_i;
    logic                  resp0_valid_o;
    logic                  resp0_ready_i;

    logic                  req1_valid_i;
    logic                  req1_ready_o;
    logic [OP_WIDTH-1:0]   req1_op_i;
    logic [DATA_WIDTH-1:0] req1_a_i;
    logic [DATA_WIDTH-1:0] req1_b_i;
    logic [DATA_WIDTH-1:0] req1_c_i;
    logic                  resp1_valid_o;
    logic                  resp1_ready_i;

    logic [DATA_WIDTH-1:0] resp_result_o;
    logic                  resp_cmp_o;
    logic                  resp_err_o;

    logic [OP_WIDTH-1:0]   alu_operator_o;
    logic [DATA_WIDTH-1:0] alu_operand_a_o;
    logic [DATA_WIDTH-1:0] alu_operand_b_o;
    logic [DATA_WIDTH-1:0] alu_operand_c_o;
    logic                  alu_enable_o;
    logic                  alu_ex_ready_o;
    logic [DATA_WIDTH-1:0] alu_result_i;
    logic                  alu_cmp_i;
    logic                  alu_ready_i;
    logic                  alu_timeout_o;

    modport slave (
        input  req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_c_i, resp0_ready_i,
        input  req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_c_i, resp1_ready_i,
        input  alu_result_i, alu_cmp_i, alu_ready_i,
        output req0_ready_o, resp0_valid_o, req1_ready_o, resp1_valid_o,
        output resp_result_o, resp_cmp_o, resp_err_o,
        output alu_operator_o, alu_operand_a_o, alu_operand_b_o, alu_operand_c_o,
        output alu_enable_o, alu_ex_ready_o, alu_timeout_o
    );

    modport master (
        output req0_valid_i, req0_op_i, req0_a_i, req0_b_i, req0_c_i, resp0_ready_i,
        output req1_valid_i, req1_op_i, req1_a_i, req1_b_i, req1_c_i, resp1_ready_i,
        output alu_result_i, alu_cmp_i, alu_ready_i,
        input  req0_ready_o, resp0_valid_o, req1_ready_o, resp1_valid_o,
        input  resp_result_o, resp_cmp_o, resp_err_o,
        input  alu_operator_o, alu_operand_a_o, alu_operand_b_o, alu_operand_c_o,
        input  alu_enable_o, alu_ex_ready_o, alu_timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arbiter
// Description : Round-robin sharing of one cv32e40p ALU between two requesters
//               with a watchdog on the ALU ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 7,
    parameter int MAX_WAIT   = 40
) (
    input  logic               clk,
    input  logic               rst,
    alu_share_arbiter_if.slave bus
);
    localparam int                  c_cnt_w    = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0]  c_max_wait = c_cnt_w'(MAX_WAIT);
    localparam logic [OP_WIDTH-1:0] c_alu_add  = OP_WIDTH'(7'b0011000);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    logic                  r_grant;
    logic                  r_last_grant;
    logic [OP_WIDTH-1:0]   r_op;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic [DATA_WIDTH-1:0] r_c;
    logic [DATA_WIDTH-1:0] r_result;
    logic                  r_cmp;
    logic                  r_err;
    logic                  r_alu_en;
    logic                  r_timeout;
    logic                  r_resp0_valid;
    logic                  r_resp1_valid;
    logic [c_cnt_w-1:0]    r_cnt;

    logic w_any;
    logic w_grant;
    logic w_resp_hs;

    // On contention the requester that was not served last wins
    assign w_any     = bus.req0_valid_i | bus.req1_valid_i;
    assign w_grant   = (bus.req0_valid_i & bus.req1_valid_i) ? ~r_last_grant : bus.req1_valid_i;
    assign w_resp_hs = r_grant ? bus.resp1_ready_i : bus.resp0_ready_i;

    assign bus.req0_ready_o = (r_state == S_IDLE) & bus.req0_valid_i & ~w_grant;
    assign bus.req1_ready_o = (r_state == S_IDLE) & bus.req1_valid_i &  w_grant;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_op          <= c_alu_add;
            r_a           <= '0;
            r_b           <= '0;
            r_c           <= '0;
            r_result      <= '0;
            r_cmp         <= 1'b0;
            r_err         <= 1'b0;
            r_alu_en      <= 1'b0;
            r_timeout     <= 1'b0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant  <= w_grant;
                        r_op     <= w_grant ? bus.req1_op_i : bus.req0_op_i;
                        r_a      <= w_grant ? bus.req1_a_i  : bus.req0_a_i;
                        r_b      <= w_grant ? bus.req1_b_i  : bus.req0_b_i;
                        r_c      <= w_grant ? bus.req1_c_i  : bus.req0_c_i;
                        r_alu_en <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (bus.alu_ready_i || (r_state == S_WAIT && r_cnt == c_max_wait)) begin
                        // A late ready on the expiry cycle still wins over the watchdog
                        r_result      <= bus.alu_ready_i ? bus.alu_result_i : '0;
                        r_cmp         <= bus.alu_ready_i ? bus.alu_cmp_i : 1'b0;
                        r_err         <= ~bus.alu_ready_i;
                        r_timeout     <= ~bus.alu_ready_i;
                        r_alu_en      <= 1'b0;
                        r_resp0_valid <= ~r_grant;
                        r_resp1_valid <=  r_grant;
                        r_cnt         <= '0;
                        r_state       <= S_RESP;
                    end else if (r_state == S_ISSUE) begin
                        r_cnt   <= c_cnt_w'(1);
                        r_state <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        r_last_grant  <= r_grant;
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.resp0_valid_o   = r_resp0_valid;
    assign bus.resp1_valid_o   = r_resp1_valid;
    assign bus.resp_result_o   = r_result;
    assign bus.resp_cmp_o      = r_cmp;
    assign bus.resp_err_o      = r_err;
    assign bus.alu_operator_o  = r_op;
    assign bus.alu_operand_a_o = r_a;
    assign bus.alu_operand_b_o = r_b;
    assign bus.alu_operand_c_o = r_c;
    assign bus.alu_enable_o    = r_alu_en;
    assign bus.alu_ex_ready_o  = r_alu_en;
    assign bus.alu_timeout_o   = r_timeout;
endmodule
`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arbiter
// Description : Directed self-checking bench for alu_share_arbiter with a small
//               behavioural ALU whose ready latency is programmable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arbiter;
    localparam logic [6:0] OP_ADD  = 7'b0011000;
    localparam logic [6:0] OP_SUB  = 7'b0011001;
    localparam logic [6:0] OP_XOR  = 7'b0101111;
    localparam logic [6:0] OP_DIVU = 7'b0110000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;
    int   en_cnt  = 0;
    int   stall   = 0;

    alu_share_arbiter_if #(.DATA_WIDTH(32), .OP_WIDTH(7)) bus ();

    alu_share_arbiter #(.DATA_WIDTH(32), .OP_WIDTH(7), .MAX_WAIT(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: ready rises after 'stall' enabled cycles
    always @(posedge clk) en_cnt <= bus.alu_enable_o ? en_cnt + 1 : 0;

    always_comb begin
        bus.alu_result_i = '0;
        case (bus.alu_operator_o)
            OP_ADD:  bus.alu_result_i = bus.alu_operand_a_o + bus.alu_operand_b_o;
            OP_SUB:  bus.alu_result_i = bus.alu_operand_a_o - bus.alu_operand_b_o;
            OP_XOR:  bus.alu_result_i = bus.alu_operand_a_o ^ bus.alu_operand_b_o;
            OP_DIVU: bus.alu_result_i = (bus.alu_operand_b_o == 0) ? '1
                                        : bus.alu_operand_a_o / bus.alu_operand_b_o;
            default: bus.alu_result_i = '0;
        endcase
        bus.alu_cmp_i   = (bus.alu_operand_a_o == bus.alu_operand_b_o);
        bus.alu_ready_i = bus.alu_enable_o && (en_cnt >= stall);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one request on 'port', checks it is accepted, then withdraws it
    task automatic send(input int port, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        if (port == 0) begin
            bus.req0_valid_i = 1'b1; bus.req0_op_i = op; bus.req0_a_i = a; bus.req0_b_i = b;
        end else begin
            bus.req1_valid_i = 1'b1; bus.req1_op_i = op; bus.req1_a_i = a; bus.req1_b_i = b;
        end
        #1;
        check("accept_ready", (port == 0) ? bus.req0_ready_o : bus.req1_ready_o, 1);
        check("other_ready",  (port == 0) ? bus.req1_ready_o : bus.req0_ready_o, 0);
        @(negedge clk);
        bus.req0_valid_i = 1'b0;
        bus.req1_valid_i = 1'b0;
    endtask

    // Samples each negedge until respN_valid; counts enable cycles and pulses
    task automatic run_wait(input int port, input int max_cyc, input logic [6:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            output logic seen, output int en_cyc, output int pulses,
                            output int unstable);
        seen = 1'b0; en_cyc = 0; pulses = 0; unstable = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (bus.alu_timeout_o) pulses++;
            if (bus.alu_enable_o) begin
                en_cyc++;
                if (bus.alu_operator_o !== op || bus.alu_operand_a_o !== a ||
                    bus.alu_operand_b_o !== b || bus.alu_ex_ready_o !== 1'b1)
                    unstable++;
            end
            if ((port == 0) ? bus.resp0_valid_o : bus.resp1_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench watchdog");
    end

    initial begin
        logic seen;
        int   en_cyc, pulses, unstable, bad;
        logic found, g;

        bus.req0_valid_i = 0; bus.req0_op_i = '0; bus.req0_a_i = '0; bus.req0_b_i = '0; bus.req0_c_i = '0;
        bus.req1_valid_i = 0; bus.req1_op_i = '0; bus.req1_a_i = '0; bus.req1_b_i = '0; bus.req1_c_i = '0;
        bus.resp0_ready_i = 1'b1;
        bus.resp1_ready_i = 1'b1;

        // Reset state
        do_reset();
        check("rst_resp0_valid", bus.resp0_valid_o, 0);
        check("rst_resp1_valid", bus.resp1_valid_o, 0);
        check("rst_result",      bus.resp_result_o, 0);
        check("rst_err",         bus.resp_err_o, 0);
        check("rst_enable",      bus.alu_enable_o, 0);
        check("rst_operator",    bus.alu_operator_o, OP_ADD);
        check("rst_timeout",     bus.alu_timeout_o, 0);

        // Single-cycle ADD on requester 0: response two cycles after accept
        send(0, OP_ADD, 32'd5, 32'd7);
        run_wait(0, 10, OP_ADD, 32'd5, 32'd7, seen, en_cyc, pulses, unstable);
        check("add_seen",    seen, 1);
        check("add_latency", en_cyc, 1);
        check("add_result",  bus.resp_result_o, 32'd12);
        check("add_err",     bus.resp_err_o, 0);
        check("add_resp1",   bus.resp1_valid_o, 0);

        // Both requesters continuously valid: grants alternate 0,1,0,1
        do_reset();
        bus.req0_valid_i = 1; bus.req0_op_i = OP_SUB; bus.req0_a_i = 32'd10;  bus.req0_b_i = 32'd3;
        bus.req1_valid_i = 1; bus.req1_op_i = OP_XOR; bus.req1_a_i = 32'hF0;  bus.req1_b_i = 32'h0F;
        for (int k = 0; k < 4; k++) begin
            found = 1'b0; g = 1'b0;
            for (int c = 0; c < 10; c++) begin
                #1;
                if (bus.req0_ready_o || bus.req1_ready_o) begin
                    found = 1'b1; g = bus.req1_ready_o;
                    break;
                end
                @(negedge clk);
            end
            check("rr_found", found, 1);
            check("rr_grant", g, k % 2);
            @(negedge clk);
            if (g)
                run_wait(1, 10, OP_XOR, 32'hF0, 32'h0F, seen, en_cyc, pulses, unstable);
            else
                run_wait(0, 10, OP_SUB, 32'd10, 32'd3, seen, en_cyc, pulses, unstable);
            check("rr_seen",   seen, 1);
            check("rr_result", bus.resp_result_o, g ? 32'hFF : 32'd7);
            check("rr_other",  g ? bus.resp0_valid_o : bus.resp1_valid_o, 0);
            if (k == 3) begin
                bus.req0_valid_i = 0; bus.req1_valid_i = 0;
            end
            @(negedge clk);
        end

        // DIVU on requester 1 with ready low for 34 cycles
        stall = 34;
        send(1, OP_DIVU, 32'd100, 32'd7);
        run_wait(1, 80, OP_DIVU, 32'd100, 32'd7, seen, en_cyc, pulses, unstable);
        check("div_seen",     seen, 1);
        check("div_en_cyc",   en_cyc, 35);
        check("div_stable",   unstable, 0);
        check("div_result",   bus.resp_result_o, 32'd14);
        check("div_err",      bus.resp_err_o, 0);
        check("div_pulses",   pulses, 0);
        check("div_en_off",   bus.alu_enable_o, 0);

        // Hung ALU: watchdog expires after 40 WAIT cycles
        stall = 1000;
        send(0, OP_ADD, 32'd1, 32'd2);
        run_wait(0, 80, OP_ADD, 32'd1, 32'd2, seen, en_cyc, pulses, unstable);
        check("to_seen",   seen, 1);
        check("to_en_cyc", en_cyc, 41);
        check("to_pulses", pulses, 1);
        check("to_result", bus.resp_result_o, 0);
        check("to_cmp",    bus.resp_cmp_o, 0);
        check("to_err",    bus.resp_err_o, 1);
        @(negedge clk);
        check("to_pulse_end", bus.alu_timeout_o, 0);

        // Response backpressure on requester 0 while requester 1 waits
        stall = 0;
        bus.resp0_ready_i = 1'b0;
        send(0, OP_ADD, 32'd5, 32'd7);
        bus.req1_valid_i = 1; bus.req1_op_i = OP_XOR; bus.req1_a_i = 32'hF0; bus.req1_b_i = 32'h0F;
        run_wait(0, 10, OP_ADD, 32'd5, 32'd7, seen, en_cyc, pulses, unstable);
        check("bp_seen", seen, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (bus.resp0_valid_o !== 1'b1 || bus.resp_result_o !== 32'd12 || bus.req1_ready_o !== 1'b0)
                bad++;
        end
        check("bp_hold", bad, 0);
        bus.resp0_ready_i = 1'b1;
        @(negedge clk);
        #1;
        check("bp_req1_accept", bus.req1_ready_o, 1);
        check("bp_resp0_drop",  bus.resp0_valid_o, 0);
        @(negedge clk);
        bus.req1_valid_i = 0;
        run_wait(1, 10, OP_XOR, 32'hF0, 32'h0F, seen, en_cyc, pulses, unstable);
        check("bp_r1_seen",   seen, 1);
        check("bp_r1_result", bus.resp_result_o, 32'hFF);

        // Reset in the middle of a DIV wait
        stall = 1000;
        send(0, OP_DIVU, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        check("mid_in_wait", bus.alu_enable_o, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_enable",   bus.alu_enable_o, 0);
        check("mid_resp0",    bus.resp0_valid_o, 0);
        check("mid_result",   bus.resp_result_o, 0);
        check("mid_operator", bus.alu_operator_o, OP_ADD);
        check("mid_operand",  bus.alu_operand_a_o, 0);
        rst = 1'b0;
        stall = 0;
        send(0, OP_ADD, 32'd5, 32'd7);
        run_wait(0, 10, OP_ADD, 32'd5, 32'd7, seen, en_cyc, pulses, unstable);
        check("post_seen",   seen, 1);
        check("post_result", bus.resp_result_o, 32'd12);
        check("post_err",    bus.resp_err_o, 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
